fifo_write_control: RTL and testbench
=====================================

FIFO_WRITE_CONTROL -- requirements
Module: fifo_write_control

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO depth in words; power of two, >= 4.
REQ-002 SHALL have parameter ALMOST_FULL_LEVEL, default DEPTH-4, fill level at or above which almost_full asserts.
REQ-003 SHALL use localparam ADDRESS_WIDTH = $clog2(DEPTH); pointers are ADDRESS_WIDTH+1 bits wide (PW).
REQ-004 SHALL have ports:
- write_clock, input, 1: sole clock; all state updates on its rising edge.
- write_reset, input, 1: synchronous, active-high reset.
- write_enable, input, 1: write request from producer.
- read_pointer_gray, input, PW: Gray-coded read pointer from the read-clock domain; asynchronous to write_clock.
- write_accepted, output, 1: combinational, write_enable && !fifo_full; drives memory write strobe.
- write_address, output, ADDRESS_WIDTH: memory write address, registered.
- write_pointer_gray, output, PW: registered Gray write pointer for the read domain.
- fifo_full, output, 1: registered full flag.
- almost_full, output, 1: registered.
- write_level, output, PW: registered fill level as seen from the write side, 0..DEPTH.

Function
REQ-005 SHALL hold binary write pointer wbin (PW bits); write_address = wbin[ADDRESS_WIDTH-1:0].
REQ-006 SHALL increment wbin by 1, modulo 2^PW, on each edge where write_accepted = 1; otherwise wbin SHALL hold.
REQ-007 SHALL register write_pointer_gray = wbin_next ^ (wbin_next >> 1) on the same edge as wbin, so it never differs from the Gray code of wbin.
REQ-008 SHALL pass read_pointer_gray through a two-flop synchronizer; the output is rq2.
REQ-009 SHALL compute fifo_full_next = (Gray(wbin_next) == {~rq2[PW-1:PW-2], rq2[PW-3:0]}); registered into fifo_full.
REQ-010 SHALL compute write_level_next = wbin_next - GrayToBin(rq2), modulo 2^PW; registered into write_level.
REQ-011 SHALL compute almost_full_next = (write_level_next >= ALMOST_FULL_LEVEL); registered into almost_full.
REQ-012 Write latency: a write accepted at edge N SHALL update write_address, write_pointer_gray, write_level and fifo_full at edge N; the write that fills the FIFO asserts fifo_full at that same edge.
REQ-013 A read_pointer_gray value stable before edge k SHALL be reflected in fifo_full, almost_full and write_level after edge k+2, and no earlier.
REQ-014 While fifo_full = 1, write_enable SHALL be ignored: no pointer change, write_accepted = 0.
REQ-015 Wrap-around of wbin from 2^PW-1 to 0 SHALL be seamless; full detection and level SHALL remain correct across the wrap.
REQ-016 fifo_full SHALL be pessimistic: it deasserts only after the synchronized read pointer advances, never early.

Reset
REQ-017 On an edge with write_reset = 1, the block SHALL clear wbin, write_pointer_gray, both synchronizer flops, write_address, write_level, fifo_full and almost_full to 0.
REQ-018 write_enable SHALL be ignored on reset edges; write_accepted SHALL be 0 while write_reset = 1.
REQ-019 Reset asserted mid-operation SHALL discard all write-side state; coordinated reset of the read side is a system-level responsibility.

Structure
REQ-020 Shared package fifo_pkg SHALL hold the bin-to-Gray and Gray-to-bin functions and the ADDRESS_WIDTH/PW derivation, shared with the read-side control block.
REQ-021 The synchronizer SHALL be a separate sub-module, pointer_synchronizer (parameter WIDTH, two stages, synchronous active-high reset), instantiated once.

Verification (DEPTH=16, ALMOST_FULL_LEVEL=12, read_pointer_gray=0 unless stated)
REQ-022 Reset, then 16 consecutive writes -> fifo_full rises at the 16th write edge; write_address 15->0; write_pointer_gray = 5'b11000; write_level = 16.
REQ-023 While full, hold write_enable high 3 cycles -> write_accepted = 0; write_address and write_pointer_gray unchanged.
REQ-024 While full, drive read_pointer_gray = 5'b00001 before edge k -> fifo_full = 0 and write_level = 15 after edge k+2, still 1 after edge k+1.
REQ-025 Write from level 11 -> almost_full asserts on the edge that makes write_level 12; it deasserts when the level drops to 11.
REQ-026 wbin = 30 with synchronized read pointer = 20 (Gray 5'b11110), then 4 writes -> wbin = 2, write_level = 14, fifo_full = 0.
REQ-027 At level 9, assert write_reset with write_enable = 1 -> all outputs 0 after that edge; no increment occurs.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: pointer widths and Gray conversions shared by the write- and read-side FIFO controls
package fifo_pkg;
    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction
endpackage

// File: rtl/pointer_synchronizer.sv
// pointer_synchronizer: two-flop synchronizer for a Gray-coded pointer crossing clock domains
module pointer_synchronizer #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/fifo_write_control.sv
// fifo_write_control: write-side pointer, full/almost-full flags and fill level of an async FIFO
module fifo_write_control
    import fifo_pkg::*;
#(
    parameter  int DEPTH             = 16,
    parameter  int ALMOST_FULL_LEVEL = DEPTH - 4,
    localparam int ADDRESS_WIDTH     = addr_width(DEPTH),
    localparam int PW                = ptr_width(DEPTH)
) (
    input  logic                     write_clock,
    input  logic                     write_reset,
    input  logic                     write_enable,
    input  logic [PW-1:0]            read_pointer_gray,
    output logic                     write_accepted,
    output logic [ADDRESS_WIDTH-1:0] write_address,
    output logic [PW-1:0]            write_pointer_gray,
    output logic                     fifo_full,
    output logic                     almost_full,
    output logic [PW-1:0]            write_level
);
    logic [PW-1:0] wbin, wbin_next, wgray_next, rq2, level_next;
    pointer_synchronizer #(.WIDTH(PW)) u_sync (
        .clk (write_clock),
        .rst (write_reset),
        .d   (read_pointer_gray),
        .q   (rq2)
    );
    assign write_accepted = write_enable && !fifo_full && !write_reset;
    assign wbin_next      = wbin + PW'(write_accepted);
    assign wgray_next     = PW'(bin2gray(32'(wbin_next)));
    assign level_next     = wbin_next - PW'(gray2bin(32'(rq2)));
    // Full when the write pointer is exactly one lap ahead: Gray form flips the top two bits
    always_ff @(posedge write_clock) begin
        if (write_reset) begin
            wbin               <= '0;
            write_address      <= '0;
            write_pointer_gray <= '0;
            fifo_full          <= 1'b0;
            almost_full        <= 1'b0;
            write_level        <= '0;
        end else begin
            wbin               <= wbin_next;
            write_address      <= wbin_next[ADDRESS_WIDTH-1:0];
            write_pointer_gray <= wgray_next;
            fifo_full          <= wgray_next == {~rq2[PW-1:PW-2], rq2[PW-3:0]};
            almost_full        <= int'(level_next) >= ALMOST_FULL_LEVEL;
            write_level        <= level_next;
        end
    end
endmodule

// File: tb/tb_fifo_write_control.sv
// tb_fifo_write_control: randomized and directed checks against a count-based FIFO model
module tb_fifo_write_control;
    logic       write_clock = 1'b0;
    logic       write_reset = 1'b0;
    logic       write_enable = 1'b0;
    logic [4:0] read_pointer_gray = '0;
    logic       write_accepted, fifo_full, almost_full;
    logic [3:0] write_address;
    logic [4:0] write_pointer_gray, write_level;
    int tests = 0, errors = 0;
    int w = 0, rb = 0, p1 = 0, p2 = 0;
    bit m_full = 1'b0;
    always #5 write_clock = ~write_clock;
    fifo_write_control dut (
        .write_clock        (write_clock),
        .write_reset        (write_reset),
        .write_enable       (write_enable),
        .read_pointer_gray  (read_pointer_gray),
        .write_accepted     (write_accepted),
        .write_address      (write_address),
        .write_pointer_gray (write_pointer_gray),
        .fifo_full          (fifo_full),
        .almost_full        (almost_full),
        .write_level        (write_level)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    // w and rb are unwrapped counts of words written and read; the model sees rb two edges late
    task automatic cycle(input bit we, input bit rst);
        int lvl, r, wm;
        r = rb & 31;
        write_enable = we;
        write_reset = rst;
        read_pointer_gray = 5'(r ^ (r >> 1));
        #1 check("write_accepted", 32'(write_accepted), 32'(we && !m_full && !rst));
        @(posedge write_clock);
        if (rst) begin
            w = 0;
            p1 = 0;
            p2 = 0;
            lvl = 0;
        end else begin
            if (we && !m_full) w++;
            lvl = (w - p2) & 31;
            p2 = p1;
            p1 = rb;
        end
        m_full = (lvl == 16);
        wm = w & 31;
        #1;
        check("write_address", 32'(write_address), 32'(w & 15));
        check("write_pointer_gray", 32'(write_pointer_gray), 32'(wm ^ (wm >> 1)));
        check("write_level", 32'(write_level), 32'(lvl));
        check("fifo_full", 32'(fifo_full), 32'(m_full));
        check("almost_full", 32'(almost_full), 32'(lvl >= 12));
        @(negedge write_clock);
    endtask
    initial begin
        @(negedge write_clock);
        rb = 0;
        cycle(1'b0, 1'b1);
        repeat (16) cycle(1'b1, 1'b0);
        check("fill_full", 32'(fifo_full), 32'd1);
        check("fill_gray", 32'(write_pointer_gray), 32'b11000);
        check("fill_level", 32'(write_level), 32'd16);
        repeat (3) cycle(1'b1, 1'b0);
        check("hold_address", 32'(write_address), 32'd0);
        rb = 1;
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        check("sync_k1_full", 32'(fifo_full), 32'd1);
        cycle(1'b0, 1'b0);
        check("sync_k2_full", 32'(fifo_full), 32'd0);
        check("sync_k2_level", 32'(write_level), 32'd15);
        rb = 0;
        cycle(1'b0, 1'b1);
        repeat (11) cycle(1'b1, 1'b0);
        check("af_below", 32'(almost_full), 32'd0);
        cycle(1'b1, 1'b0);
        check("af_rise", 32'(almost_full), 32'd1);
        rb = 1;
        repeat (3) cycle(1'b0, 1'b0);
        check("af_fall", 32'(almost_full), 32'd0);
        check("af_fall_level", 32'(write_level), 32'd11);
        rb = 0;
        cycle(1'b0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            if (rb < 20 && rb < w) rb++;
            cycle(w < 30, 1'b0);
        end
        check("wrap_pre_level", 32'(write_level), 32'd10);
        repeat (4) cycle(1'b1, 1'b0);
        check("wrap_address", 32'(write_address), 32'd2);
        check("wrap_gray", 32'(write_pointer_gray), 32'd3);
        check("wrap_level", 32'(write_level), 32'd14);
        check("wrap_full", 32'(fifo_full), 32'd0);
        rb = 0;
        cycle(1'b0, 1'b1);
        repeat (9) cycle(1'b1, 1'b0);
        check("pre_reset_level", 32'(write_level), 32'd9);
        cycle(1'b1, 1'b1);
        check("reset_outputs", {27'd0, write_address, fifo_full}, 32'd0);
        check("reset_level", 32'(write_level), 32'd0);
        for (int i = 0; i < 600; i++) begin
            bit fill_phase, rst;
            fill_phase = ((i / 100) % 2) == 0;
            if ($urandom_range(0, 99) < (fill_phase ? 25 : 70) && rb < w) rb++;
            rst = $urandom_range(0, 199) == 0;
            if (rst) rb = 0;
            cycle($urandom_range(0, 99) < (fill_phase ? 85 : 30), rst);
        end
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
